// File: rtl/scope_pkg.sv
// rtl/scope_pkg.sv - shared types and constants for the multi-channel XADC scope
package scope_pkg;

    typedef enum logic [2:0] {
        ARMED,
        WAIT_EOS,
        REQ,
        WAIT_RDY,
        WAIT_COMMIT
    } scope_state_t;

    localparam int DRP_AW   = 7;
    localparam int XADC_DW  = 16;
    localparam int XADC_MSB = 15;

endpackage

// File: rtl/scope_pingpong_ram.sv
// rtl/scope_pingpong_ram.sv - two-bank sample store for one channel, registered read
module scope_pingpong_ram #(
    parameter int DEPTH_LOG2 = 10,
    parameter int SAMPLE_W   = 10
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic                  wr_bank,
    input  logic [DEPTH_LOG2-1:0] wr_addr,
    input  logic [SAMPLE_W-1:0]   din,
    input  logic                  rd_bank,
    input  logic [DEPTH_LOG2-1:0] rd_addr,
    output logic [SAMPLE_W-1:0]   dout
);

    // Bank bit is the MSB of the flat address so each bank is one contiguous half.
    logic [SAMPLE_W-1:0] mem [2**(DEPTH_LOG2+1)];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[{wr_bank, wr_addr}] <= din;
        end
        dout <= mem[{rd_bank, rd_addr}];
    end

endmodule

// File: rtl/scope_multich_capture.sv
// rtl/scope_multich_capture.sv - multi-channel XADC DRP capture into ping-pong buffers; option SCOPE_LEVEL_TRIG_EN
module scope_multich_capture
    import scope_pkg::*;
#(
    parameter int                        NUM_CH      = 3,
    parameter int                        DEPTH_LOG2  = 10,
    parameter int                        SAMPLE_W    = 10,
    parameter logic [NUM_CH*DRP_AW-1:0]  CH_DADDR    = {7'h16, 7'h19, 7'h11},
    parameter int                        DRP_TIMEOUT = 255
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         trigger,
    input  logic                         continuous,
    input  logic [7:0]                   decim,
    input  logic                         can_commit,
    input  logic                         eos_in,
    output logic [DRP_AW-1:0]            drp_daddr,
    output logic                         drp_den,
    input  logic                         drp_drdy,
    input  logic [XADC_DW-1:0]           drp_do,
    input  logic [2:0]                   rd_ch,
    input  logic [DEPTH_LOG2-1:0]        rd_addr,
    output logic [SAMPLE_W-1:0]          rd_data,
    output logic [NUM_CH*SAMPLE_W-1:0]   latest,
`ifdef SCOPE_LEVEL_TRIG_EN
    input  logic [SAMPLE_W-1:0]          trig_level,
    input  logic                         trig_internal,
`endif
    output logic                         busy,
    output logic                         frame_done,
    output logic                         overrun,
    output logic                         drp_timeout
);

    localparam int                    TW       = $clog2(DRP_TIMEOUT + 1);
    localparam logic [2:0]            LAST_CH  = 3'(NUM_CH - 1);
    localparam logic [DEPTH_LOG2-1:0] LAST_IDX = '1;

    scope_state_t            state;
    logic                    trig_d;
    logic                    bank_sel;
    logic                    rd_live;
    logic [2:0]              ch;
    logic [2:0]              rd_ch_q;
    logic [DEPTH_LOG2-1:0]   sample_idx;
    logic [7:0]              dec_cnt;
    logic [7:0]              decim_l;
    logic [TW-1:0]           timer;
    logic                    trig_rise;
    logic                    timer_hit;
    logic                    wr_en;
    logic                    abort_probe;
    logic [SAMPLE_W-1:0]     wr_din;
    logic [SAMPLE_W-1:0]     ram_q [8];
    logic                    unused_do;

    assign trig_rise = trigger & ~trig_d;
    assign timer_hit = (timer == TW'(DRP_TIMEOUT - 1));
    assign wr_en     = (state == WAIT_RDY) && (drp_drdy || timer_hit);
    // A timed-out read stores zero rather than whatever is left on drp_do.
    assign wr_din    = drp_drdy ? drp_do[XADC_MSB -: SAMPLE_W] : '0;
    assign unused_do = ^drp_do[XADC_MSB-SAMPLE_W:0];
    assign busy      = (state != ARMED);

`ifdef SCOPE_LEVEL_TRIG_EN
    logic                probe;
    logic                prev_valid;
    logic [SAMPLE_W-1:0] prev;
    logic                crossing;

    assign crossing    = prev_valid && (prev < trig_level) && (trig_level <= wr_din);
    assign abort_probe = probe && !crossing;
`else
    assign abort_probe = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ARMED;
            trig_d      <= 1'b0;
            bank_sel    <= 1'b0;
            ch          <= '0;
            sample_idx  <= '0;
            dec_cnt     <= '0;
            decim_l     <= '0;
            timer       <= '0;
            drp_daddr   <= '0;
            drp_den     <= 1'b0;
            latest      <= '0;
            frame_done  <= 1'b0;
            overrun     <= 1'b0;
            drp_timeout <= 1'b0;
`ifdef SCOPE_LEVEL_TRIG_EN
            probe       <= 1'b0;
            prev_valid  <= 1'b0;
            prev        <= '0;
`endif
        end else begin
            trig_d     <= trigger;
            drp_den    <= 1'b0;
            frame_done <= 1'b0;
            case (state)
                ARMED: begin
`ifdef SCOPE_LEVEL_TRIG_EN
                    if (trig_internal) begin
                        if (eos_in) begin
                            ch         <= '0;
                            sample_idx <= '0;
                            probe      <= 1'b1;
                            state      <= REQ;
                        end
                    end else
`endif
                    if (trig_rise) begin
                        decim_l    <= decim;
                        sample_idx <= '0;
                        dec_cnt    <= '0;
                        state      <= WAIT_EOS;
                    end
                end
                WAIT_EOS: begin
                    if (eos_in) begin
                        if (dec_cnt == 8'd0) begin
                            ch    <= '0;
                            state <= REQ;
                        end
                        dec_cnt <= (dec_cnt == decim_l) ? 8'd0 : dec_cnt + 8'd1;
                    end
                end
                REQ: begin
                    if (eos_in) overrun <= 1'b1;
                    drp_daddr <= CH_DADDR[DRP_AW*int'(ch) +: DRP_AW];
                    drp_den   <= 1'b1;
                    timer     <= '0;
                    state     <= WAIT_RDY;
                end
                WAIT_RDY: begin
                    if (eos_in) overrun <= 1'b1;
                    if (!wr_en) begin
                        timer <= timer + 1'b1;
                    end else begin
                        latest[SAMPLE_W*int'(ch) +: SAMPLE_W] <= wr_din;
                        if (!drp_drdy) drp_timeout <= 1'b1;
`ifdef SCOPE_LEVEL_TRIG_EN
                        probe <= 1'b0;
                        if (abort_probe) begin
                            prev       <= wr_din;
                            prev_valid <= 1'b1;
                        end else if (probe) begin
                            // Crossing EOS counts as the first decimated capture.
                            decim_l <= decim;
                            dec_cnt <= (decim == 8'd0) ? 8'd0 : 8'd1;
                        end
`endif
                        if (abort_probe) begin
                            state <= ARMED;
                        end else if (ch != LAST_CH) begin
                            ch    <= ch + 3'd1;
                            state <= REQ;
                        end else if (sample_idx == LAST_IDX) begin
                            state <= WAIT_COMMIT;
                        end else begin
                            sample_idx <= sample_idx + 1'b1;
                            state      <= WAIT_EOS;
                        end
                    end
                end
                WAIT_COMMIT: begin
                    if (can_commit) begin
                        bank_sel   <= ~bank_sel;
                        frame_done <= 1'b1;
                        if (continuous) begin
                            sample_idx <= '0;
                            dec_cnt    <= '0;
                            state      <= WAIT_EOS;
                        end else begin
`ifdef SCOPE_LEVEL_TRIG_EN
                            prev_valid <= 1'b0;
`endif
                            state <= ARMED;
                        end
                    end
                end
                default: state <= ARMED;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ch_q <= '0;
            rd_live <= 1'b0;
        end else begin
            rd_ch_q <= rd_ch;
            rd_live <= 1'b1;
        end
    end

    // Unpopulated channel slots read as zero, which covers rd_ch >= NUM_CH.
    assign rd_data = rd_live ? ram_q[rd_ch_q] : '0;

    for (genvar i = 0; i < 8; i++) begin : g_ch
        if (i < NUM_CH) begin : g_ram
            scope_pingpong_ram #(
                .DEPTH_LOG2 (DEPTH_LOG2),
                .SAMPLE_W   (SAMPLE_W)
            ) u_ram (
                .clk     (clk),
                .we      (wr_en && (ch == 3'(i))),
                .wr_bank (~bank_sel),
                .wr_addr (sample_idx),
                .din     (wr_din),
                .rd_bank (bank_sel),
                .rd_addr (rd_addr),
                .dout    (ram_q[i])
            );
        end else begin : g_empty
            assign ram_q[i] = '0;
        end
    end

endmodule

// File: tb/tb_scope_multich_capture.sv
// tb/tb_scope_multich_capture.sv - randomized self-checking bench for scope_multich_capture
module tb_scope_multich_capture;

    localparam int NCH = 3;
    localparam int DL  = 4;
    localparam int SW  = 10;
    localparam int NS  = 16;
    localparam logic [6:0] ADDR_TAB [NCH] = '{7'h11, 7'h19, 7'h16};

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              trigger = 1'b0;
    logic              continuous = 1'b0;
    logic [7:0]        decim = 8'd0;
    logic              can_commit = 1'b0;
    logic              eos_in = 1'b0;
    logic [6:0]        drp_daddr;
    logic              drp_den;
    logic              drp_drdy = 1'b0;
    logic [15:0]       drp_do = 16'h0;
    logic [2:0]        rd_ch = 3'd0;
    logic [DL-1:0]     rd_addr = '0;
    logic [SW-1:0]     rd_data;
    logic [NCH*SW-1:0] latest;
    logic              busy, frame_done, overrun, drp_timeout;
`ifdef SCOPE_LEVEL_TRIG_EN
    logic [SW-1:0]     trig_level = '0;
    logic              trig_internal = 1'b0;
`endif

    int tests = 0;
    int fails = 0;

    int          drdy_lat = 3;
    logic        use_fixed = 1'b1;
    logic [15:0] fixed_do = 16'hABC0;
    logic [6:0]  addr_q [$];
    logic [SW-1:0] samp_q [$];
    logic [SW-1:0] mm [2][NCH][NS];
    logic        model_bank = 1'b0;
    logic [SW-1:0] got [4][NS];
    logic [NCH*SW-1:0] exp_latest;

    scope_multich_capture #(
        .NUM_CH     (NCH),
        .DEPTH_LOG2 (DL),
        .SAMPLE_W   (SW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .trigger     (trigger),
        .continuous  (continuous),
        .decim       (decim),
        .can_commit  (can_commit),
        .eos_in      (eos_in),
        .drp_daddr   (drp_daddr),
        .drp_den     (drp_den),
        .drp_drdy    (drp_drdy),
        .drp_do      (drp_do),
        .rd_ch       (rd_ch),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .latest      (latest),
`ifdef SCOPE_LEVEL_TRIG_EN
        .trig_level    (trig_level),
        .trig_internal (trig_internal),
`endif
        .busy        (busy),
        .frame_done  (frame_done),
        .overrun     (overrun),
        .drp_timeout (drp_timeout)
    );

    always #5 clk = ~clk;

    // DRP slave: records each request and answers drdy_lat cycles after den (0 = never).
    initial begin : responder
        logic [15:0] d;
        forever begin
            @(posedge clk); #1;
            if (drp_den === 1'b1) begin
                addr_q.push_back(drp_daddr);
                if (drdy_lat == 0) begin
                    samp_q.push_back('0);
                end else begin
                    d = use_fixed ? fixed_do : 16'($urandom);
                    samp_q.push_back(d[15 -: SW]);
                    repeat (drdy_lat) @(posedge clk);
                    #1 drp_drdy = 1'b1; drp_do = d;
                    @(posedge clk); #1 drp_drdy = 1'b0;
                end
            end
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        #2 reset = 1'b1;
        trigger = 1'b0; eos_in = 1'b0; can_commit = 1'b0; continuous = 1'b0; decim = 8'd0;
        tick(3);
        reset = 1'b0;
        tick(1);
        addr_q.delete(); samp_q.delete();
        model_bank = 1'b0;
    endtask

    task automatic pulse_trigger;
        trigger = 1'b1; tick(2); trigger = 1'b0; tick(2);
    endtask

    task automatic pulse_eos;
        eos_in = 1'b1; tick(1); eos_in = 1'b0;
    endtask

    task automatic send_eos(input int n, input int gap);
        repeat (n) begin
            pulse_eos();
            tick(gap - 1);
        end
    endtask

    // Model: k-th DRP read lands at channel k%NCH, sample k/NCH of the capture bank.
    task automatic capture_frame(output int bad_addr);
        logic cb;
        logic [6:0] a;
        logic [SW-1:0] s;
        cb = ~model_bank;
        bad_addr = 0;
        for (int k = 0; k < NCH*NS; k++) begin
            if (addr_q.size() == 0) begin
                bad_addr++;
            end else begin
                a = addr_q.pop_front();
                s = samp_q.pop_front();
                if (a !== ADDR_TAB[k % NCH]) bad_addr++;
                mm[cb][k % NCH][k / NCH] = s;
                exp_latest[(k % NCH)*SW +: SW] = s;
            end
        end
    endtask

    task automatic commit(output int pulses);
        can_commit = 1'b1;
        pulses = 0;
        repeat (6) begin
            tick(1);
            if (frame_done === 1'b1) pulses++;
        end
        can_commit = 1'b0;
        model_bank = ~model_bank;
    endtask

    task automatic read_all;
        for (int c = 0; c < 4; c++) begin
            for (int a = 0; a < NS; a++) begin
                rd_ch = 3'(c); rd_addr = DL'(a);
                tick(1);
                got[c][a] = rd_data;
            end
        end
    endtask

    task automatic test_reset;
        tick(2);
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
        tests++; if (drp_den !== 1'b0) begin fails++; $display("FAIL reset_den: got %b want 0", drp_den); end
        tests++; if ({frame_done, overrun, drp_timeout} !== 3'b000) begin fails++; $display("FAIL reset_flags: got %b want 000", {frame_done, overrun, drp_timeout}); end
        tests++; if (latest !== '0) begin fails++; $display("FAIL reset_latest: got %h want 0", latest); end
        tests++; if (rd_data !== '0) begin fails++; $display("FAIL reset_rd_data: got %h want 0", rd_data); end
        tests++; if (drp_daddr !== 7'h0) begin fails++; $display("FAIL reset_daddr: got %h want 0", drp_daddr); end
        reset = 1'b0;
        tick(1);
    endtask

    task automatic test_single_shot;
        int bad, pulses;
        logic [SW-1:0] e;
        do_reset();
        use_fixed = 1'b1; drdy_lat = 3;
        pulse_trigger();
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL ss_armed: got busy %b want 1", busy); end
        send_eos(NS, 25);
        tests++; if (addr_q.size() !== NCH*NS) begin fails++; $display("FAIL ss_req_count: got %0d want %0d", addr_q.size(), NCH*NS); end
        capture_frame(bad);
        tests++; if (bad !== 0) begin fails++; $display("FAIL ss_addr_seq: got %0d bad want 0", bad); end
        tests++; if (latest !== {NCH{10'h2AF}}) begin fails++; $display("FAIL ss_latest: got %h want %h", latest, {NCH{10'h2AF}}); end
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL ss_wait_commit: got busy %b want 1", busy); end
        commit(pulses);
        tests++; if (pulses !== 1) begin fails++; $display("FAIL ss_frame_done: got %0d pulses want 1", pulses); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL ss_rearm: got busy %b want 0", busy); end
        read_all();
        for (int c = 0; c < 4; c++) for (int a = 0; a < NS; a++) begin
            e = (c < NCH) ? 10'h2AF : 10'h0;
            tests++;
            if (got[c][a] !== e) begin fails++; $display("FAIL ss_data ch%0d[%0d]: got %h want %h", c, a, got[c][a], e); end
        end
    endtask

    task automatic test_decim;
        int bad, pulses;
        logic [SW-1:0] e;
        use_fixed = 1'b0; drdy_lat = 3;
        decim = 8'd2;
        pulse_trigger();
        decim = 8'd0;
        send_eos(45, 25);
        tests++; if (addr_q.size() !== 45) begin fails++; $display("FAIL dec_45eos: got %0d reqs want 45", addr_q.size()); end
        send_eos(1, 25);
        tests++; if (addr_q.size() !== 48) begin fails++; $display("FAIL dec_46eos: got %0d reqs want 48", addr_q.size()); end
        send_eos(3, 25);
        tests++; if (addr_q.size() !== 48) begin fails++; $display("FAIL dec_commit_eos: got %0d reqs want 48", addr_q.size()); end
        tests++; if (overrun !== 1'b0) begin fails++; $display("FAIL dec_overrun: got %b want 0", overrun); end
        capture_frame(bad);
        tests++; if (bad !== 0) begin fails++; $display("FAIL dec_addr_seq: got %0d bad want 0", bad); end
        commit(pulses);
        tests++; if (pulses !== 1) begin fails++; $display("FAIL dec_frame_done: got %0d want 1", pulses); end
        read_all();
        for (int c = 0; c < 4; c++) for (int a = 0; a < NS; a++) begin
            e = (c < NCH) ? mm[model_bank][c][a] : 10'h0;
            tests++;
            if (got[c][a] !== e) begin fails++; $display("FAIL dec_data ch%0d[%0d]: got %h want %h", c, a, got[c][a], e); end
        end
    endtask

    task automatic test_timeout;
        int bad, pulses, w;
        logic [SW-1:0] e;
        do_reset();
        use_fixed = 1'b0; drdy_lat = 0;
        pulse_trigger();
        pulse_eos();
        w = 0;
        while (drp_den !== 1'b1 && w < 20) begin tick(1); w++; end
        tests++; if (drp_den !== 1'b1) begin fails++; $display("FAIL to_den: got %b want 1", drp_den); end
        tick(240);
        tests++; if (drp_timeout !== 1'b0) begin fails++; $display("FAIL to_early: got %b want 0", drp_timeout); end
        tick(30);
        tests++; if (drp_timeout !== 1'b1) begin fails++; $display("FAIL to_flag: got %b want 1", drp_timeout); end
        tick(600);
        tests++; if (addr_q.size() !== NCH) begin fails++; $display("FAIL to_continue: got %0d reqs want %0d", addr_q.size(), NCH); end
        drdy_lat = 3;
        send_eos(NS - 1, 25);
        capture_frame(bad);
        tests++; if (bad !== 0) begin fails++; $display("FAIL to_addr_seq: got %0d bad want 0", bad); end
        commit(pulses);
        tests++; if (pulses !== 1) begin fails++; $display("FAIL to_frame_done: got %0d want 1", pulses); end
        tests++; if (drp_timeout !== 1'b1) begin fails++; $display("FAIL to_sticky: got %b want 1", drp_timeout); end
        read_all();
        for (int c = 0; c < 4; c++) for (int a = 0; a < NS; a++) begin
            e = (c < NCH) ? mm[model_bank][c][a] : 10'h0;
            tests++;
            if (got[c][a] !== e) begin fails++; $display("FAIL to_data ch%0d[%0d]: got %h want %h", c, a, got[c][a], e); end
        end
    endtask

    task automatic test_overrun;
        int bad, pulses;
        do_reset();
        use_fixed = 1'b0; drdy_lat = 10;
        pulse_trigger();
        pulse_eos();
        tick(5);
        pulse_eos();
        tests++; if (overrun !== 1'b1) begin fails++; $display("FAIL ovr_flag: got %b want 1", overrun); end
        tick(43);
        send_eos(NS - 2, 50);
        tests++; if (addr_q.size() !== NCH*(NS-1)) begin fails++; $display("FAIL ovr_idx: got %0d reqs want %0d", addr_q.size(), NCH*(NS-1)); end
        send_eos(1, 50);
        tests++; if (addr_q.size() !== NCH*NS) begin fails++; $display("FAIL ovr_req_count: got %0d want %0d", addr_q.size(), NCH*NS); end
        capture_frame(bad);
        tests++; if (bad !== 0) begin fails++; $display("FAIL ovr_addr_seq: got %0d bad want 0", bad); end
        tests++; if (latest !== exp_latest) begin fails++; $display("FAIL ovr_latest: got %h want %h", latest, exp_latest); end
        commit(pulses);
        tests++; if (pulses !== 1) begin fails++; $display("FAIL ovr_frame_done: got %0d want 1", pulses); end
        tests++; if (overrun !== 1'b1) begin fails++; $display("FAIL ovr_sticky: got %b want 1", overrun); end
    endtask

    task automatic test_continuous;
        int bad, pulses;
        logic [SW-1:0] e;
        do_reset();
        continuous = 1'b1; use_fixed = 1'b0; drdy_lat = 3;
        pulse_trigger();
        send_eos(NS, 25);
        capture_frame(bad);
        tests++; if (bad !== 0) begin fails++; $display("FAIL cont_addr_seq: got %0d bad want 0", bad); end
        pulses = 0;
        repeat (100) begin tick(1); if (frame_done === 1'b1) pulses++; end
        tests++; if (pulses !== 0) begin fails++; $display("FAIL cont_hold: got %0d swaps want 0", pulses); end
        read_all();
        for (int c = 0; c < NCH; c++) for (int a = 0; a < NS; a++) begin
            tests++;
            if (got[c][a] !== mm[model_bank][c][a]) begin fails++; $display("FAIL cont_old ch%0d[%0d]: got %h want %h", c, a, got[c][a], mm[model_bank][c][a]); end
        end
        commit(pulses);
        tests++; if (pulses !== 1) begin fails++; $display("FAIL cont_swap: got %0d want 1", pulses); end
        read_all();
        for (int c = 0; c < NCH; c++) for (int a = 0; a < NS; a++) begin
            tests++;
            if (got[c][a] !== mm[model_bank][c][a]) begin fails++; $display("FAIL cont_new ch%0d[%0d]: got %h want %h", c, a, got[c][a], mm[model_bank][c][a]); end
        end
        send_eos(NS, 25);
        tests++; if (addr_q.size() !== NCH*NS) begin fails++; $display("FAIL cont_rearm: got %0d reqs want %0d", addr_q.size(), NCH*NS); end
        capture_frame(bad);
        commit(pulses);
        tests++; if (pulses !== 1) begin fails++; $display("FAIL cont_swap2: got %0d want 1", pulses); end
        read_all();
        for (int c = 0; c < 4; c++) for (int a = 0; a < NS; a++) begin
            e = (c < NCH) ? mm[model_bank][c][a] : 10'h0;
            tests++;
            if (got[c][a] !== e) begin fails++; $display("FAIL cont_frame2 ch%0d[%0d]: got %h want %h", c, a, got[c][a], e); end
        end
    endtask

    task automatic test_reset_midway;
        int bad, pulses;
        logic [SW-1:0] e;
        do_reset();
        use_fixed = 1'b0; drdy_lat = 20;
        pulse_trigger();
        pulse_eos();
        tick(4);
        pulse_eos();
        tests++; if (overrun !== 1'b1) begin fails++; $display("FAIL rst_pre_overrun: got %b want 1", overrun); end
        #3 reset = 1'b1;
        #1;
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rst_busy: got %b want 0", busy); end
        tests++; if ({drp_den, frame_done, overrun, drp_timeout} !== 4'b0000) begin fails++; $display("FAIL rst_flags: got %b want 0000", {drp_den, frame_done, overrun, drp_timeout}); end
        tests++; if (latest !== '0) begin fails++; $display("FAIL rst_latest: got %h want 0", latest); end
        tick(30);
        reset = 1'b0;
        tick(1);
        addr_q.delete(); samp_q.delete();
        model_bank = 1'b0;
        drdy_lat = 3;
        pulse_trigger();
        send_eos(NS, 25);
        tests++; if (addr_q.size() !== NCH*NS) begin fails++; $display("FAIL rst_restart: got %0d reqs want %0d", addr_q.size(), NCH*NS); end
        capture_frame(bad);
        tests++; if (bad !== 0) begin fails++; $display("FAIL rst_addr_seq: got %0d bad want 0", bad); end
        commit(pulses);
        tests++; if (pulses !== 1) begin fails++; $display("FAIL rst_frame_done: got %0d want 1", pulses); end
        read_all();
        for (int c = 0; c < 4; c++) for (int a = 0; a < NS; a++) begin
            e = (c < NCH) ? mm[model_bank][c][a] : 10'h0;
            tests++;
            if (got[c][a] !== e) begin fails++; $display("FAIL rst_data ch%0d[%0d]: got %h want %h", c, a, got[c][a], e); end
        end
    endtask

    initial begin
        test_reset();
        test_single_shot();
        test_decim();
        test_timeout();
        test_overrun();
        test_continuous();
        test_reset_midway();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/scope_multich_capture.md
Name: scope_multich_capture

Overview:
- Parametrised successor of the single-trigger XADC scope: captures NUM_CH XADC channels per end-of-sequence into per-channel ping-pong waveform buffers of 2**DEPTH_LOG2 samples.
- Drives the XADC DRP as a proper den/drdy master, including a timeout. Supports single-shot or continuous re-arm, EOS decimation, and a last-value register per channel.
- Sits between the xadc_wiz instance (instantiated outside this block) and the waveform display/readout logic.

Parameters:
- NUM_CH, 3, number of captured channels (1..8).
- DEPTH_LOG2, 10, log2 samples per channel per frame.
- SAMPLE_W, 10, stored sample width (1..12).
- CH_DADDR, {7'h16,7'h19,7'h11}, packed NUM_CH*7 DRP addresses; channel i = bits [7i+6:7i].
- DRP_TIMEOUT, 255, cycles to wait for drdy before abandoning a read.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- trigger  in  1  external trigger; rising edge is sampled
- continuous  in  1  1 = auto re-arm after commit; 0 = single-shot
- decim  in  8  capture every (decim+1)th EOS; latched at trigger
- can_commit  in  1  consumer permits bank swap
- eos_in  in  1  XADC eos_out, 1-cycle pulse
- drp_daddr  out  7  DRP address
- drp_den  out  1  DRP enable, 1-cycle pulse
- drp_drdy  in  1  DRP data ready
- drp_do  in  16  DRP read data
- rd_ch  in  3  readout channel select
- rd_addr  in  DEPTH_LOG2  readout sample index
- rd_data  out  SAMPLE_W  committed-bank sample, 1-cycle latency
- latest  out  NUM_CH*SAMPLE_W  most recent sample per channel
- busy  out  1  high in any state except ARMED
- frame_done  out  1  1-cycle pulse on bank swap
- overrun  out  1  sticky: EOS arrived during a read burst
- drp_timeout  out  1  sticky: drdy missing for DRP_TIMEOUT cycles

Behaviour:
- Reset (async): state=ARMED; bank_sel=0; every output 0; sticky flags cleared. RAM contents not cleared.
- Sample extraction: sample = drp_do[15 -: SAMPLE_W], MSB-aligned 12-bit XADC code, truncated.
- States:
  - ARMED: wait for a trigger rising edge (registered edge detect); then latch decim, sample_idx=0, dec_cnt=0, go to WAIT_EOS.
  - WAIT_EOS: on eos_in, if dec_cnt==0 then ch=0 and go to REQ; dec_cnt = (dec_cnt==decim_l) ? 0 : dec_cnt+1. The first EOS after the trigger is always captured.
  - REQ: drive drp_daddr=CH_DADDR[ch] and drp_den=1 for exactly one cycle; clear timer; go to WAIT_RDY.
  - WAIT_RDY: on drp_drdy, write the sample to capture bank (~bank_sel), channel ch, address sample_idx, and update latest[ch].
    - If the timer reaches DRP_TIMEOUT first: write 0, set drp_timeout, continue as if drdy arrived.
    - Then: if ch<NUM_CH-1, ch++ and go to REQ. Otherwise, if sample_idx==2**DEPTH_LOG2-1 go to WAIT_COMMIT; else sample_idx++ and go to WAIT_EOS.
  - WAIT_COMMIT: when can_commit=1, bank_sel toggles and frame_done pulses in the same clock edge. Next state is WAIT_EOS if continuous (idx/dec reset), else ARMED.
- eos_in in REQ/WAIT_RDY: ignored and overrun set. eos_in in ARMED/WAIT_COMMIT: ignored, no flag.
- trigger outside ARMED: ignored. Trigger edge and can_commit both high in WAIT_COMMIT: commit only.
- Readout: rd_data = bank[bank_sel][rd_ch][rd_addr], registered. A swap takes effect on reads issued the cycle after frame_done. rd_ch>=NUM_CH returns 0.
- Latency: one capture set = NUM_CH*(2 + drdy latency) cycles after EOS.

Optional Feature:
- Macro SCOPE_LEVEL_TRIG_EN.
- With the macro: adds ports trig_level in SAMPLE_W and trig_internal in 1.
  - When trig_internal=1, ARMED ignores trigger and instead reads channel 0 on every EOS through REQ/WAIT_RDY.
  - It fires on a rising crossing: prev<trig_level<=cur.
  - The crossing sample is stored at index 0 for all channels (remaining channels read in the same burst), then the FSM proceeds as after a normal trigger. prev is invalidated on entry to ARMED.
- Without the macro: ports absent; external trigger only.

Decomposition:
- Package scope_pkg: state enum (ARMED, WAIT_EOS, REQ, WAIT_RDY, WAIT_COMMIT), DRP address width 7, XADC data width 16, sample MSB position 15.
- Sub-module scope_pingpong_ram: one instance per channel via generate.
  - Two banks of 2**DEPTH_LOG2 x SAMPLE_W.
  - Write port (we, bank, addr, din) and registered read port (bank, addr).

Test Plan:
- NUM_CH=3, DEPTH_LOG2=4, decim=0, single-shot; trigger, 16 EOS with drp_do=16'hABC0 and drdy 3 cycles after den -> daddr sequence 11,19,16 per EOS; after can_commit, rd_data=10'h2AF for all ch/addr; frame_done one pulse; state ARMED.
- decim=2 -> captures on EOS #1,4,7,…; 16 samples need 46 EOS.
- drdy never asserted -> after 255 cycles sample 0 written, drp_timeout=1, FSM continues.
- EOS pulse during WAIT_RDY -> overrun=1, sample_idx unchanged.
- continuous=1, can_commit held low for 100 cycles -> no swap, rd_data keeps old bank; raising can_commit -> bank swaps, capture restarts without a trigger.
- Assert reset in WAIT_RDY -> busy=0, bank_sel=0, flags 0 immediately; next trigger restarts at idx 0.
